// File: rtl/qam_frame_scheduler.sv
// Frame sequencer for the 64-QAM symbol mapper: pilots then data symbols, an idle
// guard gap between frames, FIFO/underrun stalls and a per-symbol timeout.
module qam_frame_scheduler #(
   parameter int unsigned SYMS_PER_FRAME = 64,
   parameter int unsigned PILOT_SYMS     = 2,
   parameter int unsigned GAP_CYCLES     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       data_clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       stop,
   input  logic       src_valid,
   input  logic       i_q_data_fifo_full,
   input  logic       new_symbol,
   output logic       enable_fsm,
   output logic       bit_req,
   output logic       pilot_sel,
   output logic       frame_active,
   output logic       frame_done,
   output logic [7:0] sym_index,
   output logic       timeout_err
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0]       LAST_SYM  = 8'(SYMS_PER_FRAME - 1);
   localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [8:0]       PILOT_LIM = 9'(PILOT_SYMS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_GAP
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       sym_q, sym_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             stop_q, stop_d;
   logic             tmo_err_q, tmo_err_d;
   logic             enable_q, enable_d;
   logic             bit_req_q, bit_req_d;
   logic             pilot_q, pilot_d;
   logic             active_q, active_d;
   logic             done_q, done_d;

   logic is_pilot;
   logic can_issue;
   logic sym_last;
   logic tmo_hit;
   logic gap_last;
   logic stop_seen;

   assign is_pilot  = ({1'b0, sym_q} < PILOT_LIM);
   assign can_issue = !i_q_data_fifo_full && (is_pilot || src_valid);
   assign sym_last  = (sym_q == LAST_SYM);
   assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
   assign gap_last  = (gap_cnt_q == GAP_LAST);
   assign stop_seen = stop_q || stop;

   always_ff @(posedge data_clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sym_q     <= '0;
         tmo_cnt_q <= '0;
         gap_cnt_q <= '0;
         stop_q    <= 1'b0;
         tmo_err_q <= 1'b0;
         enable_q  <= 1'b0;
         bit_req_q <= 1'b0;
         pilot_q   <= 1'b0;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_q     <= sym_d;
         tmo_cnt_q <= tmo_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         stop_q    <= stop_d;
         tmo_err_q <= tmo_err_d;
         enable_q  <= enable_d;
         bit_req_q <= bit_req_d;
         pilot_q   <= pilot_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sym_d     = sym_q;
      tmo_cnt_d = tmo_cnt_q;
      gap_cnt_d = gap_cnt_q;
      stop_d    = stop_q;
      tmo_err_d = tmo_err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ISSUE;
               sym_d     = '0;
               tmo_err_d = 1'b0;
            end
         end
         S_ISSUE: begin
            if (can_issue) begin
               state_d   = S_WAIT;
               tmo_cnt_d = '0;
            end
         end
         S_WAIT: begin
            if (new_symbol) begin
               if (sym_last) begin
                  state_d   = S_GAP;
                  gap_cnt_d = '0;
               end else begin
                  state_d = S_ISSUE;
                  sym_d   = sym_q + 8'd1;
               end
            end else if (tmo_hit) begin
               state_d   = S_IDLE;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         S_GAP: begin
            if (gap_last) begin
               if (cont && !stop_seen) begin
                  state_d = S_ISSUE;
                  sym_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // stop only matters inside a frame; it is dropped whenever we head back to IDLE
      if ((state_q != S_IDLE) && stop) begin
         stop_d = 1'b1;
      end
      if (state_d == S_IDLE) begin
         stop_d = 1'b0;
      end
   end

   // Outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      enable_d  = (state_q == S_ISSUE) && can_issue;
      bit_req_d = (state_d == S_WAIT);
      pilot_d   = ((state_d == S_ISSUE) || (state_d == S_WAIT)) &&
                  ({1'b0, sym_d} < PILOT_LIM);
      active_d  = (state_d != S_IDLE);
      done_d    = (state_q == S_WAIT) && new_symbol && sym_last;
   end

   assign enable_fsm   = enable_q;
   assign bit_req      = bit_req_q;
   assign pilot_sel    = pilot_q;
   assign frame_active = active_q;
   assign frame_done   = done_q;
   assign sym_index    = sym_q;
   assign timeout_err  = tmo_err_q;

endmodule
